// File: rtl/dphy_hs_rx_deser.sv
// dphy_hs_rx_deser: MIPI D-PHY HS lane DDR deserialiser with sync hunt and byte alignment.
// Optional macro DPHY_SYNC_TOLERANT_EN accepts a leader with one bit error (flagged on Sync_Err).
`default_nettype none

module dphy_hs_rx_deser #(
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter int         HUNT_TIMEOUT = 64
) (
  input  logic       RX_DDR_clk,
  input  logic       RX_rst,
  input  logic       Enable,
  input  logic       Dp,
  input  logic       Dn,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Valid,
  output logic       Rx_Sync_Det,
  output logic       Rx_Active,
  output logic       Sync_Err
);

  localparam int HCW = $clog2(HUNT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             b1_q, b2_q;
  logic [8:0]       sr_q;
  logic [HCW-1:0]   hunt_cnt_q, hunt_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sync_det_q, sync_det_d;
  logic             sync_err_q, sync_err_d;

  logic             line_bit;
  logic [7:0]       win0, win1;
  logic             win0_exact, win1_exact;
  logic             match, match_phase, match_err;

  // An undriven/equal line pair decodes as 0.
  assign line_bit = (Dp != Dn) ? Dp : 1'b0;

  always_ff @(posedge RX_DDR_clk or posedge RX_rst) begin
    if (RX_rst) begin
      b1_q <= 1'b0;
    end else begin
      b1_q <= line_bit;
    end
  end

  always_ff @(negedge RX_DDR_clk or posedge RX_rst) begin
    if (RX_rst) begin
      b2_q <= 1'b0;
    end else begin
      b2_q <= line_bit;
    end
  end

  // Newest bit enters at the MSB; nine bits cover both candidate windows.
  always_ff @(posedge RX_DDR_clk or posedge RX_rst) begin
    if (RX_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= {b2_q, b1_q, sr_q[8:2]};
    end
  end

  assign win0       = sr_q[8:1];
  assign win1       = sr_q[7:0];
  assign win0_exact = (win0 == SYNC_WORD);
  assign win1_exact = (win1 == SYNC_WORD);

`ifdef DPHY_SYNC_TOLERANT_EN
  logic win0_near, win1_near;
  assign win0_near = ($countones(win0 ^ SYNC_WORD) <= 1);
  assign win1_near = ($countones(win1 ^ SYNC_WORD) <= 1);
`endif

  always_comb begin
    match       = 1'b0;
    match_phase = 1'b0;
    match_err   = 1'b0;
    if (win1_exact) begin
      match       = 1'b1;
      match_phase = 1'b1;
    end else if (win0_exact) begin
      match       = 1'b1;
`ifdef DPHY_SYNC_TOLERANT_EN
    end else if (win1_near) begin
      match       = 1'b1;
      match_phase = 1'b1;
      match_err   = 1'b1;
    end else if (win0_near) begin
      match       = 1'b1;
      match_err   = 1'b1;
`endif
    end
  end

  always_ff @(posedge RX_DDR_clk or posedge RX_rst) begin
    if (RX_rst) begin
      state_q    <= ST_IDLE;
      hunt_cnt_q <= '0;
      byte_cnt_q <= 2'd0;
      phase_q    <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      sync_det_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hunt_cnt_q <= hunt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      phase_q    <= phase_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      sync_det_q <= sync_det_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hunt_cnt_d = hunt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    phase_d    = phase_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    sync_det_d = 1'b0;
    sync_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d    = ST_HUNT;
          hunt_cnt_d = '0;
        end
      end
      ST_HUNT: begin
        if (match) begin
          phase_d    = match_phase;
          byte_cnt_d = 2'd0;
          sync_det_d = 1'b1;
          sync_err_d = match_err;
          state_d    = ST_ACTIVE;
        end else if (hunt_cnt_q == HCW'(HUNT_TIMEOUT - 1)) begin
          sync_err_d = 1'b1;
          state_d    = ST_FAIL;
        end else if (hunt_cnt_q < HCW'(HUNT_TIMEOUT)) begin
          hunt_cnt_d = hunt_cnt_q + HCW'(1);
        end
      end
      ST_ACTIVE: begin
        // The byte counter is zero on the first cycle after lock, so a full
        // byte has arrived whenever it reads 3.
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          rx_byte_d  = phase_q ? win1 : win0;
          rx_valid_d = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!Enable) begin
      state_d    = ST_IDLE;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      sync_det_d = 1'b0;
      sync_err_d = 1'b0;
    end
  end

  assign Rx_Byte     = rx_byte_q;
  assign Rx_Valid    = rx_valid_q;
  assign Rx_Sync_Det = sync_det_q;
  assign Sync_Err    = sync_err_q;
  assign Rx_Active   = (state_q == ST_ACTIVE);

endmodule

`default_nettype wire
